tx_seq_ctrl: RTL and testbench
==============================

Name: tx_seq_ctrl

Overview:
- Sequencer for the transmit chain: PRBS9 I/Q generators -> oversampled polyphase TX filters -> noise stage.
- Generates the symbol-rate strobe that advances the PRBS generators and the polyphase phase index for the filters.
- Runs a fill / run / drain state machine so downstream logging and the noise stage see only samples from a fully primed filter.
- Flushes the filter delay line with zeros on stop.

Parameters:
OVERSAMP, 4, samples per symbol; power of two, ≥2
NB_PH, 2, width of phase index, = log2(OVERSAMP)
NBAUD, 6, filter span in symbols; symbol periods spent in fill and in drain
NB_CNT, 32, width of emitted-symbol counter

Ports:
clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_run  in  1  run request; level-sensitive, sampled only at symbol boundaries (and in IDLE)
o_phase  out  NB_PH  polyphase index for the TX filters, 0..OVERSAMP-1
o_filt_shift  out  1  one-cycle strobe; filter shifts in a new symbol
o_prbs_en  out  1  one-cycle strobe; PRBS generators advance one bit
o_shift_zero  out  1  filter shifts a zero instead of the PRBS symbol
o_out_valid  out  1  filter output is valid (primed by real data)
o_busy  out  1  state machine is not IDLE
o_sym_cnt  out  NB_CNT  PRBS symbols emitted since last start; saturating

Behaviour:
- All outputs are registered.
- Reset (i_reset=0, async): state IDLE; all outputs 0; internal symbol counter 0.
- States: IDLE, FILL, RUN, DRAIN. A symbol boundary is a cycle with o_phase==OVERSAMP-1.
- Phase counter:
  - Runs in all non-IDLE states, incrementing every cycle and wrapping OVERSAMP-1 -> 0.
  - Holds 0 in IDLE.
  - o_filt_shift=1 exactly in non-IDLE cycles with o_phase==0.
  - o_prbs_en = o_filt_shift in FILL/RUN, 0 in DRAIN.
- IDLE -> FILL:
  - When i_run=1 is sampled, the next cycle shows FILL, o_phase=0, o_filt_shift=1, o_prbs_en=1, o_busy=1.
  - o_sym_cnt clears to 0 on this transition.
- FILL -> RUN: after NBAUD shifts, at the symbol boundary, provided i_run=1.
  - First RUN cycle: o_phase=0, o_out_valid=1.
- FILL, i_run=0 at a boundary: FILL -> DRAIN with o_out_valid held 0. An aborted fill never asserts valid.
- RUN -> DRAIN: only when i_run=0 is sampled at a symbol boundary.
  - i_run changes at any other phase are ignored; the current symbol always completes.
- DRAIN:
  - o_shift_zero=1 and o_prbs_en=0.
  - Exactly NBAUD shifts.
  - o_out_valid keeps its value from entry (1 if entered from RUN).
  - After the NBAUD-th symbol period, at the boundary -> IDLE with all strobes, o_shift_zero, o_out_valid and o_busy = 0.
  - i_run is ignored during DRAIN; if it is still 1 in IDLE, a new FILL starts the following cycle. Minimum one IDLE cycle between runs.
- Fill/drain counter: counts o_filt_shift pulses; 0..NBAUD-1; cleared on each state entry.
- o_sym_cnt: +1 per o_prbs_en; saturates at 2^NB_CNT-1; holds its value in DRAIN and IDLE for readout.
- Reset asserted mid-operation: immediate return to the reset values above; no drain is performed.

Test Plan (OVERSAMP=4, NBAUD=6 unless noted):
1. Release reset, i_run=1 from cycle 0:
   - FILL o_filt_shift/o_prbs_en pulses at cycles 1, 5, 9, 13, 17, 21.
   - RUN from cycle 25 with o_out_valid=1 and o_phase sequence 0,1,2,3 repeating.
   - o_sym_cnt=7 at cycle 26.
2. In RUN, drop i_run while o_phase=1:
   - Symbol completes; DRAIN starts at the next phase 0 with o_shift_zero=1, o_prbs_en=0, o_out_valid=1.
   - 6 o_filt_shift pulses, then IDLE 24 cycles after DRAIN entry, o_busy=0.
   - o_sym_cnt frozen.
3. In RUN, 1-cycle i_run=0 glitch at o_phase=2 -> no state change; strobes continue with period 4.
4. Drop i_run during FILL after 2 shifts:
   - DRAIN at next boundary with o_out_valid=0 throughout, 6 zero shifts, then IDLE.
   - o_out_valid never 1.
5. Assert i_reset=0 mid-RUN, between clock edges -> all outputs 0 before the next clk edge; after release, IDLE with i_run=1 starts FILL cleanly.
6. NB_CNT=4, long RUN -> o_sym_cnt reaches 15 and stays 15; a new start clears it to 0, then 1 on the first FILL shift.

Source files
------------

// File: rtl/tx_seq_ctrl.sv
// TX chain sequencer: symbol strobe, polyphase index and
// fill/run/drain control for the PRBS -> filter -> noise path.
module tx_seq_ctrl #(
  parameter int OVERSAMP = 4,
  parameter int NB_PH    = 2,
  parameter int NBAUD    = 6,
  parameter int NB_CNT   = 32
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_run,
  output logic [NB_PH-1:0]  o_phase,
  output logic              o_filt_shift,
  output logic              o_prbs_en,
  output logic              o_shift_zero,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic [NB_CNT-1:0] o_sym_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } state_t;

  localparam int CW = $clog2(NBAUD + 1);
  localparam logic [NB_PH-1:0] PH_LAST = NB_PH'(OVERSAMP - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBAUD - 1);

  state_t state;
  state_t state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic bnd;
  logic cnt_done;

  logic [NB_PH-1:0]  phase_nx;
  logic              shift_nx;
  logic              prbs_nx;
  logic              zero_nx;
  logic              valid_nx;
  logic              busy_nx;
  logic [NB_CNT-1:0] sc_nx;

  assign bnd      = (state != IDLE) && (o_phase == PH_LAST);
  assign cnt_done = (cnt == CNT_LAST);

  // State and fill/drain symbol counter registers
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: transitions only at symbol boundaries once active
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_run) state_nx = FILL;
      end
      FILL: begin
        if (bnd) begin
          if (!i_run)        state_nx = DRAIN;
          else if (cnt_done) state_nx = RUN;
        end
      end
      RUN: begin
        if (bnd && !i_run) state_nx = DRAIN;
      end
      DRAIN: begin
        if (bnd && cnt_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    cnt_nx = cnt;
    if (state_nx != state) begin
      cnt_nx = '0;
    end else if (bnd && (state == FILL || state == DRAIN)) begin
      cnt_nx = cnt + CW'(1);
    end
  end

  // Output decode: values the registered outputs take next cycle
  always_comb begin
    phase_nx = '0;
    if (state != IDLE && state_nx != IDLE) begin
      phase_nx = o_phase + NB_PH'(1);
    end
    shift_nx = (state_nx != IDLE) && (phase_nx == '0);
    prbs_nx  = shift_nx && (state_nx == FILL || state_nx == RUN);
    zero_nx  = (state_nx == DRAIN);
    busy_nx  = (state_nx != IDLE);
    valid_nx = 1'b0;
    unique case (state_nx)
      RUN:     valid_nx = 1'b1;
      DRAIN:   valid_nx = (state == DRAIN) ? o_out_valid
                                           : (state == RUN);
      default: valid_nx = 1'b0;
    endcase
    sc_nx = o_sym_cnt;
    if (state == IDLE && state_nx == FILL) begin
      sc_nx = '0;
    end else if (o_prbs_en && (o_sym_cnt != '1)) begin
      sc_nx = o_sym_cnt + NB_CNT'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_phase      <= '0;
      o_filt_shift <= 1'b0;
      o_prbs_en    <= 1'b0;
      o_shift_zero <= 1'b0;
      o_out_valid  <= 1'b0;
      o_busy       <= 1'b0;
      o_sym_cnt    <= '0;
    end else begin
      o_phase      <= phase_nx;
      o_filt_shift <= shift_nx;
      o_prbs_en    <= prbs_nx;
      o_shift_zero <= zero_nx;
      o_out_valid  <= valid_nx;
      o_busy       <= busy_nx;
      o_sym_cnt    <= sc_nx;
    end
  end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Bench for tx_seq_ctrl: table vectors, directed corners,
// random run/reset stimulus against a timeline model.
module tb_tx_seq_ctrl;

  localparam int OV = 4;
  localparam int NP = 2;
  localparam int NB = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;

  logic [NP-1:0] ph, ph4;
  logic sh, pe, sz, ov, bz;
  logic sh4, pe4, sz4, ov4, bz4;
  logic [31:0] sc;
  logic [3:0]  sc4;

  tx_seq_ctrl #(.OVERSAMP(OV), .NB_PH(NP), .NBAUD(NB),
                .NB_CNT(32)) dut (
    .clk(clk), .i_reset(rst), .i_run(run),
    .o_phase(ph), .o_filt_shift(sh), .o_prbs_en(pe),
    .o_shift_zero(sz), .o_out_valid(ov), .o_busy(bz),
    .o_sym_cnt(sc)
  );

  tx_seq_ctrl #(.OVERSAMP(OV), .NB_PH(NP), .NBAUD(NB),
                .NB_CNT(4)) dut4 (
    .clk(clk), .i_reset(rst), .i_run(run),
    .o_phase(ph4), .o_filt_shift(sh4), .o_prbs_en(pe4),
    .o_shift_zero(sz4), .o_out_valid(ov4), .o_busy(bz4),
    .o_sym_cnt(sc4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit vseen;
  int nsh;

  // timeline model: t counts cycles since session start
  bit m_act, m_fill, m_drain, m_valid;
  int m_t, m_dstart;
  longint m_sc;

  task automatic m_reset();
    m_act = 0; m_fill = 0; m_drain = 0; m_valid = 0;
    m_t = 0; m_dstart = 0; m_sc = 0;
  endtask

  function automatic bit e_shift();
    return m_act && (m_t % OV == 0);
  endfunction

  function automatic bit e_prbs();
    return e_shift() && !m_drain;
  endfunction

  task automatic m_edge(bit r);
    if (e_prbs()) m_sc++;
    if (!m_act) begin
      if (r) begin
        m_act = 1; m_t = 0; m_fill = 1; m_drain = 0;
        m_valid = 0; m_sc = 0;
      end
    end else begin
      if (m_t % OV == OV - 1) begin
        if (m_drain) begin
          if ((m_t - m_dstart) / OV == NB - 1) m_act = 0;
        end else if (!r) begin
          m_drain = 1; m_fill = 0; m_dstart = m_t + 1;
        end else if (m_fill && (m_t / OV == NB - 1)) begin
          m_fill = 0; m_valid = 1;
        end
      end
      m_t++;
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    longint s4;
    s4 = (m_sc > 15) ? 15 : m_sc;
    chk("phase", ph, m_act ? (m_t % OV) : 0);
    chk("filt_shift", sh, e_shift());
    chk("prbs_en", pe, e_prbs());
    chk("shift_zero", sz, m_act && m_drain);
    chk("out_valid", ov, m_act && m_valid);
    chk("busy", bz, m_act);
    chk("sym_cnt", sc, m_sc);
    chk("sym_cnt4", sc4, s4);
    chk("busy4", bz4, m_act);
  endtask

  task automatic tick();
    if (!rst) m_reset();
    else m_edge(run);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
    if (ov) vseen = 1;
    if (sh) nsh++;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    int cyc; int ph; bit sh; bit pe; bit sz;
    bit ov; bit bz; longint sc;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{0,  0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1,  0, 1, 1, 0, 0, 1, 0};
    vt[2] = '{2,  1, 0, 0, 0, 0, 1, 1};
    vt[3] = '{5,  0, 1, 1, 0, 0, 1, 1};
    vt[4] = '{21, 0, 1, 1, 0, 0, 1, 5};
    vt[5] = '{24, 3, 0, 0, 0, 0, 1, 6};
    vt[6] = '{25, 0, 1, 1, 0, 1, 1, 6};
    vt[7] = '{26, 1, 0, 0, 0, 1, 1, 7};
    vt[8] = '{29, 0, 1, 1, 0, 1, 1, 7};
    vt[9] = '{30, 1, 0, 0, 0, 1, 1, 8};

    m_reset();
    repeat (3) @(negedge clk);
    check_all();

    // start with i_run=1 from cycle 0
    rst = 1; run = 1; cyc = 0;
    for (int i = 0; i < 10; i++) begin
      while (cyc < vt[i].cyc) tick();
      chk($sformatf("tbl%0d_phase", i), ph, vt[i].ph);
      chk($sformatf("tbl%0d_shift", i), sh, vt[i].sh);
      chk($sformatf("tbl%0d_prbs", i), pe, vt[i].pe);
      chk($sformatf("tbl%0d_zero", i), sz, vt[i].sz);
      chk($sformatf("tbl%0d_valid", i), ov, vt[i].ov);
      chk($sformatf("tbl%0d_busy", i), bz, vt[i].bz);
      chk($sformatf("tbl%0d_symcnt", i), sc, vt[i].sc);
    end

    // drop run at phase 1: symbol completes, then drain
    run = 0;
    ticks(3);
    chk("drain_entry_phase", ph, 0);
    chk("drain_entry_zero", sz, 1);
    chk("drain_entry_prbs", pe, 0);
    chk("drain_entry_valid", ov, 1);
    nsh = sh ? 1 : 0;
    ticks(23);
    chk("drain_shift_count", nsh, 6);
    chk("drain_last_busy", bz, 1);
    tick();
    chk("drain_exit_busy", bz, 0);
    chk("drain_exit_valid", ov, 0);
    chk("drain_symcnt_frozen", sc, 8);

    // one-cycle glitch at phase 2 in RUN is ignored
    run = 1;
    ticks(25);
    chk("run2_phase", ph, 0);
    chk("run2_valid", ov, 1);
    ticks(2);
    chk("glitch_phase", ph, 2);
    run = 0;
    tick();
    run = 1;
    tick();
    chk("glitch_shift", sh, 1);
    chk("glitch_zero", sz, 0);
    chk("glitch_valid", ov, 1);
    ticks(4);
    chk("glitch_shift2", sh, 1);
    chk("glitch_busy", bz, 1);

    // drain back to idle
    run = 0;
    ticks(28);
    chk("idle_before_abort", bz, 0);

    // abort fill after 2 shifts
    run = 1;
    vseen = 0;
    nsh = 0;
    ticks(5);
    chk("abort_shifts", nsh, 2);
    tick();
    run = 0;
    ticks(3);
    chk("abort_drain_zero", sz, 1);
    chk("abort_drain_valid", ov, 0);
    ticks(24);
    chk("abort_idle_busy", bz, 0);
    chk("abort_never_valid", vseen, 0);

    // async reset mid-RUN, between clock edges
    run = 1;
    ticks(27);
    chk("prereset_valid", ov, 1);
    #2 rst = 0;
    #1;
    chk("rst_busy", bz, 0);
    chk("rst_valid", ov, 0);
    chk("rst_shift", sh, 0);
    chk("rst_phase", ph, 0);
    chk("rst_symcnt", sc, 0);
    m_reset();
    @(negedge clk);
    cyc++;
    check_all();
    rst = 1;
    tick();
    chk("restart_shift", sh, 1);
    chk("restart_prbs", pe, 1);
    chk("restart_busy", bz, 1);

    // 4-bit counter saturates, clears on restart
    ticks(72);
    chk("sat_sc4", sc4, 15);
    run = 0;
    ticks(32);
    chk("sat_idle", bz, 0);
    chk("sat_hold", sc4, 15);
    run = 1;
    tick();
    chk("sat_clear", sc4, 0);
    tick();
    chk("sat_first", sc4, 1);

    // random run/reset stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if (run ? ($urandom_range(0, 59) == 0)
              : ($urandom_range(0, 14) == 0))
        run = ~run;
      rst = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
